// File: rtl/key_debounce_if.sv
// key_debounce_if -- groups the raw key inputs and debounced key outputs.
//   KEY         : raw push-button levels, active-low, asynchronous
//   key_level   : debounced state, 1 = pressed
//   key_press   : one-cycle pulse per accepted press
//   key_release : one-cycle pulse per accepted release
//   key_repeat  : auto-repeat pulses while held
//   any_pressed : OR of key_level
// master = side that drives KEY; slave = the debouncer.
interface key_debounce_if;
  logic [3:0] KEY;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;
  logic       any_pressed;

  modport master (
    output KEY,
    input  key_level, key_press, key_release, key_repeat, any_pressed
  );

  modport slave (
    input  KEY,
    output key_level, key_press, key_release, key_repeat, any_pressed
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce -- four independent push-button debouncers with press/release
// pulses and auto-repeat.
//   CLK_50A : single clock, rising edge
//   reset   : asynchronous, active-high
//   kb      : key_debounce_if slave (KEY in, level/pulse outputs)
//
// Per-key FSM:
//   state           | meaning
//   RELEASED        | key accepted as up
//   PRESS_PENDING   | raw input says down, counting stable samples
//   PRESSED         | key accepted as down
//   RELEASE_PENDING | raw input says up, counting stable samples
module key_debounce #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic          CLK_50A,
  input  logic          reset,
  key_debounce_if.slave kb
);

  localparam int unsigned SW      = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);

  // The sample that enters a pending state is the first of the run and the
  // counter starts at zero there, so the run completes when it reads N-2.
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 2);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } state_e;

  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    raw_pressed;
  state_e        state_q   [4];
  logic [SW-1:0] stb_cnt_q [4];
  logic [RW-1:0] rep_cnt_q [4];
  logic [3:0]    rep_armed_q;
  logic [3:0]    level_q;
  logic [3:0]    press_q;
  logic [3:0]    release_q;
  logic [3:0]    repeat_q;

  // Synchronizer resets to 1 so that keys read as released.
  always_ff @(posedge CLK_50A or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= kb.KEY;
      sync2_q <= sync1_q;
    end
  end

  assign raw_pressed = ~sync2_q;

  always_ff @(posedge CLK_50A or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]   <= RELEASED;
        stb_cnt_q[i] <= '0;
        rep_cnt_q[i] <= '0;
      end
      rep_armed_q <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        // Repeat timer: first interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
        if (level_q[i]) begin
          if (rep_cnt_q[i] == (rep_armed_q[i] ? PER_LAST : DLY_LAST)) begin
            rep_cnt_q[i]   <= '0;
            rep_armed_q[i] <= 1'b1;
            repeat_q[i]    <= 1'b1;
          end else begin
            rep_cnt_q[i] <= rep_cnt_q[i] + RW'(1);
          end
        end

        case (state_q[i])
          RELEASED: begin
            if (raw_pressed[i]) begin
              state_q[i]   <= PRESS_PENDING;
              stb_cnt_q[i] <= '0;
            end
          end
          PRESS_PENDING: begin
            if (!raw_pressed[i]) begin
              state_q[i]   <= RELEASED;
              stb_cnt_q[i] <= '0;
            end else if (stb_cnt_q[i] == STB_LAST) begin
              state_q[i]     <= PRESSED;
              stb_cnt_q[i]   <= '0;
              level_q[i]     <= 1'b1;
              press_q[i]     <= 1'b1;
              rep_cnt_q[i]   <= '0;
              rep_armed_q[i] <= 1'b0;
            end else begin
              stb_cnt_q[i] <= stb_cnt_q[i] + SW'(1);
            end
          end
          PRESSED: begin
            if (!raw_pressed[i]) begin
              state_q[i]   <= RELEASE_PENDING;
              stb_cnt_q[i] <= '0;
            end
          end
          RELEASE_PENDING: begin
            if (raw_pressed[i]) begin
              state_q[i]   <= PRESSED;
              stb_cnt_q[i] <= '0;
            end else if (stb_cnt_q[i] == STB_LAST) begin
              state_q[i]     <= RELEASED;
              stb_cnt_q[i]   <= '0;
              level_q[i]     <= 1'b0;
              release_q[i]   <= 1'b1;
              // A repeat landing on the falling cycle is dropped.
              repeat_q[i]    <= 1'b0;
              rep_cnt_q[i]   <= '0;
              rep_armed_q[i] <= 1'b0;
            end else begin
              stb_cnt_q[i] <= stb_cnt_q[i] + SW'(1);
            end
          end
          default: begin
            state_q[i]   <= RELEASED;
            stb_cnt_q[i] <= '0;
          end
        endcase
      end
    end
  end

  assign kb.key_level   = level_q;
  assign kb.key_press   = press_q;
  assign kb.key_release = release_q;
  assign kb.key_repeat  = repeat_q;
  assign kb.any_pressed = |level_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce -- directed bench for key_debounce with
// STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Expected pulses are queued as (cycle, kind, key) when stimulus is driven
// and popped when the DUT reaches that cycle.
module tb_key_debounce;
  localparam int S   = 4;
  localparam int D   = 10;
  localparam int PER = 3;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_REP   = 2;

  typedef struct {
    int cyc;
    int kind;
    int key;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  key_debounce_if kb ();

  key_debounce #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (D),
    .REPEAT_PERIOD(PER)
  ) dut (
    .CLK_50A(clk),
    .reset  (rst),
    .kb     (kb)
  );

  always #5 clk = ~clk;

  ev_t        sb[$];
  int         edge_n    = 0;
  int         tests     = 0;
  int         fails     = 0;
  logic [3:0] exp_level = '0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic [3:0] ep;
    logic [3:0] er;
    logic [3:0] et;
    ep = '0;
    er = '0;
    et = '0;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc == edge_n) begin
        case (sb[j].kind)
          K_PRESS: ep[sb[j].key] = 1'b1;
          K_REL:   er[sb[j].key] = 1'b1;
          default: et[sb[j].key] = 1'b1;
        endcase
        sb.delete(j);
      end
    end
    exp_level = (exp_level | ep) & ~er;
    chk("key_press",   kb.key_press,   ep);
    chk("key_release", kb.key_release, er);
    chk("key_repeat",  kb.key_repeat,  et);
    chk("key_level",   kb.key_level,   exp_level);
    chk("any_pressed", {3'b000, kb.any_pressed}, {3'b000, |exp_level});
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      check_cycle();
    end
  endtask

  // Call right after KEY[k] goes low (at a negedge); sampled at edge_n+1.
  task automatic expect_press(input int k);
    int p;
    p = edge_n + 1 + S + 1;
    sb.push_back('{p, K_PRESS, k});
    for (int t = p + D; t < p + 300; t += PER) sb.push_back('{t, K_REP, k});
  endtask

  // Call right after KEY[k] goes high for the final time.
  task automatic expect_release(input int k);
    int r;
    r = edge_n + 1 + S + 1;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].key == k && sb[j].kind == K_REP && sb[j].cyc >= r) sb.delete(j);
    end
    sb.push_back('{r, K_REL, k});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_level"},   kb.key_level,   4'b0000);
    chk({tag, "_press"},   kb.key_press,   4'b0000);
    chk({tag, "_release"}, kb.key_release, 4'b0000);
    chk({tag, "_repeat"},  kb.key_repeat,  4'b0000);
    chk({tag, "_any"},     {3'b000, kb.any_pressed}, 4'b0000);
  endtask

  initial begin
    kb.KEY = 4'hF;
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    tick(3);
    rst = 1'b0;
    tick(3);

    // Single press/release on key 0; other keys must stay quiet.
    kb.KEY[0] = 1'b0; expect_press(0);
    tick(8);
    kb.KEY[0] = 1'b1; expect_release(0);
    tick(8);

    // 3-cycle glitch on key 1: nothing expected.
    kb.KEY[1] = 1'b0;
    tick(3);
    kb.KEY[1] = 1'b1;
    tick(8);

    // Key 2 held ~30 cycles past press: repeats at P+10, P+13, ...
    kb.KEY[2] = 1'b0; expect_press(2);
    tick(35);
    kb.KEY[2] = 1'b1; expect_release(2);
    tick(10);

    // Key 1 released so the fall coincides with a would-be repeat at P+13.
    kb.KEY[1] = 1'b0; expect_press(1);
    tick(13);
    kb.KEY[1] = 1'b1; expect_release(1);
    tick(10);

    // Key 3 release with 1-cycle low bounces; repeat continues meanwhile.
    kb.KEY[3] = 1'b0; expect_press(3);
    tick(7);
    kb.KEY[3] = 1'b1; tick(2);
    kb.KEY[3] = 1'b0; tick(1);
    kb.KEY[3] = 1'b1; tick(2);
    kb.KEY[3] = 1'b0; tick(1);
    kb.KEY[3] = 1'b1; expect_release(3);
    tick(12);

    // Reset while key 0 is held and repeating.
    kb.KEY[0] = 1'b0; expect_press(0);
    tick(19);
    rst = 1'b1;
    #1 check_all_zero("mid_reset");
    sb.delete();
    exp_level = '0;
    tick(2);
    rst = 1'b0; expect_press(0);
    tick(20);
    kb.KEY[0] = 1'b1; expect_release(0);
    tick(8);

    // Keys 0 and 3 together.
    kb.KEY[0] = 1'b0; expect_press(0);
    kb.KEY[3] = 1'b0; expect_press(3);
    tick(7);
    kb.KEY[0] = 1'b1; expect_release(0);
    kb.KEY[3] = 1'b1; expect_release(3);
    tick(8);

    chk("scoreboard_empty", {3'b000, sb.size() == 0}, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000000: consecutive synchronized samples a key must hold a new state before it is accepted (20 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000: cycles from the key_press cycle to the first key_repeat pulse; legal range >= 2.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent key_repeat pulses; legal range >= 2.
REQ-004 SHALL have port CLK_50A, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port KEY, input, 4 bits: raw push-button levels, asynchronous to CLK_50A, active-low (0 = pressed).
REQ-007 SHALL have port key_level, output, 4 bits: debounced key state, active-high (1 = pressed).
REQ-008 SHALL have port key_press, output, 4 bits: one-cycle pulse per accepted press.
REQ-009 SHALL have port key_release, output, 4 bits: one-cycle pulse per accepted release.
REQ-010 SHALL have port key_repeat, output, 4 bits: auto-repeat pulses while a key is held.
REQ-011 SHALL have port any_pressed, output, 1 bit: OR of key_level.

Function
REQ-012 Each KEY bit SHALL pass through a 2-flop synchronizer and then be inverted to give raw_pressed[i].
REQ-013 Each key SHALL be fully independent, with its own synchronizer, counters and 4-state FSM: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
REQ-014 FSM transitions:
- RELEASED -> PRESS_PENDING when raw_pressed=1.
- PRESS_PENDING -> RELEASED when raw_pressed=0; the stability counter clears.
- PRESS_PENDING -> PRESSED when raw_pressed=1 on the STABLE_CYCLES-th consecutive sample.
- PRESSED and RELEASE_PENDING behave symmetrically for raw_pressed=0.
REQ-015 The stability counter SHALL be ceil(log2(STABLE_CYCLES+1)) bits wide, clear on every state change, and never wrap.
REQ-016 key_level[i] SHALL be 1 in PRESSED and RELEASE_PENDING and 0 otherwise; it is a registered output.
REQ-017 Latency: if KEY[i] is first sampled low at edge E and stays low, key_level[i] SHALL be 1 after edge E+STABLE_CYCLES+1. The same latency SHALL apply to a release.
REQ-018 Any single sample that disagrees with the pending state SHALL abort the pending transition; glitches shorter than STABLE_CYCLES samples SHALL produce no output activity.
REQ-019 key_press[i] SHALL be high exactly in the first cycle key_level[i] reads 1; key_release[i] SHALL be high exactly in the first cycle key_level[i] reads 0 after having been 1.
REQ-020 Auto-repeat: let P be the key_press cycle. key_repeat[i] SHALL pulse for one cycle at P+REPEAT_DELAY and then at P+REPEAT_DELAY+n*REPEAT_PERIOD, while key_level[i]=1.
REQ-021 Repeat pulses SHALL continue through RELEASE_PENDING. The repeat counter SHALL clear and pulses SHALL stop from the cycle key_level[i] falls, including a pulse that would coincide with that cycle.
REQ-022 key_press, key_release and key_repeat SHALL never be high on the same key in the same cycle.
REQ-023 Several keys MAY assert pulses in the same cycle.
REQ-024 The repeat counter SHALL saturate-free wrap only by reload to zero at each pulse; its width SHALL be ceil(log2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)).
REQ-025 any_pressed SHALL equal the OR of the four key_level bits in the same cycle.

Reset
REQ-026 While reset=1, asynchronously:
- synchronizer flops SHALL be set to 1 (released);
- all FSMs SHALL be set to RELEASED;
- all counters SHALL be cleared;
- key_level, key_press, key_release, key_repeat and any_pressed SHALL be 0.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard all progress with no pulse emitted.
REQ-028 A key held through reset deassertion SHALL be debounced afresh and produce exactly one key_press, per REQ-017.

Verification (STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 KEY[0] held low from sample edge E -> key_level[0]=1 after edge E+5, key_press[0] high for one cycle, any_pressed=1, no activity on keys 1-3.
REQ-030 KEY[1] low for 3 cycles then high -> key_level[1] stays 0, no pulses on any output.
REQ-031 KEY[2] held low 30 cycles past press -> key_repeat[2] at P+10, P+13, P+16, ...; release -> key_release[2] once, no further repeats.
REQ-032 KEY[3] released with 1-cycle low bounces during the release window -> key_level[3] drops only after 4 consecutive high samples; exactly one key_release.
REQ-033 reset pulsed while KEY[0] pressed and repeating -> all outputs 0 immediately; after deassertion, a single key_press[0] at edge +5, then repeat restarts from that press.
REQ-034 KEY[0] and KEY[3] asserted on the same edge -> key_press[0] and key_press[3] pulse in the same cycle.
